// File: rtl/buffered_data_adapter_pkg.sv
// Shared helpers for the buffered data adapter: pointer wrap rule and
// occupancy counter width.
package adapter_pkg;

  // Occupancy counter must represent 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Ring-pointer advance; depth need not be a power of two.
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/buffered_data_adapter_if.sv
// Producer/consumer bus of the buffered data adapter.
// Handshakes: a word moves on a rising edge when start_tx && available (push) or
// out_valid && out_ack (pop); available/out_valid never depend on start_tx/out_ack.
interface buffered_data_adapter_if #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 4
) ();
  import adapter_pkg::*;

  localparam int CW = cnt_width(DEPTH);

  logic             start_tx;
  logic [WIDTH-1:0] dat_in;
  logic             available;
  logic             almost_full;
  logic [WIDTH-1:0] dat_out;
  logic             out_valid;
  logic             out_ack;
  logic             tx_complete;
  logic [CW-1:0]    count;

  modport slave (
    input  start_tx, dat_in, out_ack,
    output available, almost_full, dat_out, out_valid, tx_complete, count
  );

  modport master (
    output start_tx, dat_in, out_ack,
    input  available, almost_full, dat_out, out_valid, tx_complete, count
  );
endinterface

// File: rtl/buffered_data_adapter_storage.sv
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous
// read port. Contents are deliberately not reset.
module adapter_storage #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);
  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/buffered_data_adapter.sv
// Show-ahead ring buffer between a producer (start_tx/available) and a consumer
// (out_valid/out_ack), with occupancy, almost-full and per-word completion pulse.
module buffered_data_adapter
  import adapter_pkg::*;
#(
  parameter int WIDTH    = 128,
  parameter int DEPTH    = 4,
  parameter int AF_LEVEL = DEPTH - 1
) (
  input logic                     clk,
  input logic                     rst,
  buffered_data_adapter_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = cnt_width(DEPTH);

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_tx_complete;

  logic          w_available;
  logic          w_out_valid;
  logic          w_push;
  logic          w_pop;

  // Flags decode only the registered count, so no input-to-output paths exist.
  assign w_available = (r_count < CW'(DEPTH));
  assign w_out_valid = (r_count != '0);
  assign w_push      = bus.start_tx && w_available;
  assign w_pop       = bus.out_ack  && w_out_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_tx_complete <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= PW'(ptr_inc(32'(r_wr_ptr), DEPTH));
      if (w_pop)  r_rd_ptr <= PW'(ptr_inc(32'(r_rd_ptr), DEPTH));
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      r_tx_complete <= w_pop;
    end
  end

  adapter_storage #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_storage (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr),
    .i_wdata (bus.dat_in),
    .i_raddr (r_rd_ptr),
    .o_rdata (bus.dat_out)
  );

  assign bus.available   = w_available;
  assign bus.out_valid   = w_out_valid;
  assign bus.almost_full = (r_count >= CW'(AF_LEVEL));
  assign bus.tx_complete = r_tx_complete;
  assign bus.count       = r_count;
endmodule

// File: tb/tb_buffered_data_adapter.sv
// Bench for buffered_data_adapter: queue-based reference model and monitor on a
// DEPTH=4 instance, plus a directed wrap-around run on a DEPTH=3 instance.
module tb_buffered_data_adapter;
  localparam int W  = 128;
  localparam int D  = 4;
  localparam int AF = 3;

  logic clk;
  logic rst;

  buffered_data_adapter_if #(.WIDTH(W), .DEPTH(D)) bus ();
  buffered_data_adapter_if #(.WIDTH(8), .DEPTH(3)) bus3 ();

  buffered_data_adapter #(.WIDTH(W), .DEPTH(D), .AF_LEVEL(AF)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  buffered_data_adapter #(.WIDTH(8), .DEPTH(3)) u_dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: stored words in arrival order plus last-pop flag.
  logic [W-1:0] exp_q[$];
  int           m_cnt = 0;
  logic         m_txc = 1'b0;
  logic [7:0]   q3[$];

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver: inputs applied 1 time unit after an edge, held through the next edge
  task automatic drive(input logic st, input logic [W-1:0] d, input logic ack);
    bus.start_tx = st;
    bus.dat_in   = d;
    bus.out_ack  = ack;
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: a word joins the queue when there is room, leaves when
  // the consumer acks a non-empty buffer.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_cnt = 0;
      m_txc = 1'b0;
      exp_q.delete();
    end else begin
      automatic bit push_ok = bus.start_tx && (m_cnt < D);
      automatic bit pop_ok  = bus.out_ack && (m_cnt > 0);
      if (push_ok) exp_q.push_back(bus.dat_in);
      m_cnt = m_cnt + int'(push_ok) - int'(pop_ok);
      m_txc = pop_ok;
    end
  end

  // monitor: mid-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (rst) begin
      check("count",       bus.count,       W'(m_cnt));
      check("available",   bus.available,   W'(m_cnt < D));
      check("out_valid",   bus.out_valid,   W'(m_cnt > 0));
      check("almost_full", bus.almost_full, W'(m_cnt >= AF));
      check("tx_complete", bus.tx_complete, W'(m_txc));
      if (m_cnt > 0) begin
        if (bus.out_ack) check("pop_data", bus.dat_out, exp_q.pop_front());
        else             check("head_data", bus.dat_out, exp_q[0]);
      end
    end
  end

  initial begin
    #1000000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    rst = 1'b0;
    bus.start_tx = 1'b0; bus.dat_in = '0; bus.out_ack = 1'b0;
    bus3.start_tx = 1'b0; bus3.dat_in = '0; bus3.out_ack = 1'b0;
    #2;
    check("rst_count",       bus.count,       '0);
    check("rst_available",   bus.available,   1);
    check("rst_out_valid",   bus.out_valid,   0);
    check("rst_almost_full", bus.almost_full, 0);
    check("rst_tx_complete", bus.tx_complete, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    repeat (2) drive(0, '0, 0);

    // fill to full, then an ignored extra push
    for (int i = 0; i < 4; i++) begin
      drive(1, W'(8'hA1 + i), 0);
      check("fill_count", bus.count, W'(i + 1));
      check("fill_af",    bus.almost_full, W'(i >= 2));
    end
    check("full_available", bus.available, 0);
    drive(1, W'(8'hA5), 0);
    check("ignored_push_count", bus.count, 4);

    // drain in order, each pop followed by one completion pulse
    for (int i = 0; i < 4; i++) begin
      check("drain_data", bus.dat_out, W'(8'hA1 + i));
      drive(0, '0, 1);
      check("drain_txc", bus.tx_complete, 1);
    end
    check("drained_valid", bus.out_valid, 0);
    drive(0, '0, 1);
    check("empty_ack_txc", bus.tx_complete, 0);

    // simultaneous push/pop at count 2, at full, and at empty
    drive(1, W'(8'hB1), 0);
    drive(1, W'(8'hB2), 0);
    drive(1, W'(8'hB3), 1);
    check("simul_mid_count", bus.count, 2);
    check("simul_mid_head",  bus.dat_out, W'(8'hB2));
    drive(1, W'(8'hB4), 0);
    drive(1, W'(8'hB5), 0);
    drive(1, W'(8'hB6), 1);
    check("simul_full_count", bus.count, 3);
    repeat (3) drive(0, '0, 1);
    drive(1, W'(8'hC1), 1);
    check("simul_empty_count", bus.count, 1);
    check("simul_empty_txc",   bus.tx_complete, 0);

    // back-pressure: head word must hold while unacked
    for (int i = 0; i < 5; i++) begin
      drive(0, '0, 0);
      check("hold_data", bus.dat_out, W'(8'hC1));
    end
    drive(0, '0, 1);

    // asynchronous reset with three words stored, between clock edges
    for (int i = 0; i < 3; i++) drive(1, W'(8'hD0 + i), 0);
    check("pre_rst_count", bus.count, 3);
    bus.start_tx = 1'b0; bus.out_ack = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_count",     bus.count,       0);
    check("async_rst_out_valid", bus.out_valid,   0);
    check("async_rst_available", bus.available,   1);
    check("async_rst_txc",       bus.tx_complete, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    // randomized traffic, alternating fill-biased and drain-biased phases
    for (int i = 0; i < 400; i++) begin
      automatic int p = ((i / 40) % 2 == 0) ? 75 : 25;
      drive($urandom_range(0, 99) < p, {$urandom, $urandom, $urandom, $urandom},
            $urandom_range(0, 99) >= p);
    end
    drive(0, '0, 0);

    // wrap-around on DEPTH=3 with up to 2 words outstanding
    for (int i = 0; i < 12; i++) begin
      bus3.start_tx = (i < 10);
      bus3.dat_in   = 8'(i);
      bus3.out_ack  = (i >= 2);
      @(negedge clk);
      if (bus3.out_ack && q3.size() > 0) begin
        check("wrap_valid", bus3.out_valid, 1);
        check("wrap_data",  bus3.dat_out, W'(q3.pop_front()));
      end
      @(posedge clk); #1;
      if (bus3.start_tx) q3.push_back(8'(i));
      check("wrap_count", bus3.count, W'(q3.size()));
    end
    bus3.start_tx = 1'b0; bus3.out_ack = 1'b0;
    check("wrap_empty", bus3.out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/buffered_data_adapter.md
Name: buffered_data_adapter

Overview:
- Single-clock, parametrised successor to the one-deep handshake transfer register.
- Holds up to DEPTH words of WIDTH bits in arrival order.
- Producer side: start_tx / available handshake. Consumer side: valid / ack handshake.
- Adds occupancy reporting, an almost-full flag and a per-word completion pulse.
- Sits between a producer unit (e.g. fetch or load path) and a consumer that cannot accept every cycle.

Parameters:
- WIDTH, 128, data word width in bits.
- DEPTH, 4, number of storage entries. Any integer >= 2; need not be a power of two.
- AF_LEVEL, DEPTH-1, occupancy at or above which almost_full asserts. Legal range 1..DEPTH.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- start_tx  in  1  producer requests write of dat_in this cycle.
- dat_in  in  WIDTH  producer data.
- available  out  1  at least one free entry (count < DEPTH).
- almost_full  out  1  count >= AF_LEVEL.
- dat_out  out  WIDTH  oldest stored word (show-ahead).
- out_valid  out  1  dat_out holds a valid word (count > 0).
- out_ack  in  1  consumer takes dat_out this cycle.
- tx_complete  out  1  one-cycle pulse: a word was consumed on the previous edge.
- count  out  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Reset (rst low, asynchronous, any time including mid-transfer):
  - write pointer, read pointer and count go to 0; tx_complete goes to 0.
  - available = 1, out_valid = 0, almost_full = 0, count = 0.
  - dat_out is don't-care and is not reset. Storage contents are not reset.
  - In-flight words are discarded.
- Push: accepted when start_tx && available at the rising edge.
  - dat_in is written to entry wr_ptr.
  - wr_ptr advances, wrapping from DEPTH-1 to 0.
- Push while full (available=0): ignored. No write, no pointer or count change, no error flag.
- Pop: accepted when out_ack && out_valid at the rising edge.
  - rd_ptr advances with the same wrap rule.
  - tx_complete = 1 for exactly the following cycle.
- Pop while empty: ignored. tx_complete stays 0.
- Simultaneous accepted push and pop: count unchanged; both pointers advance.
- Full and both requested: push is rejected because available=0 at the edge; pop proceeds. No same-cycle bypass.
- Empty and both requested: pop is rejected; push proceeds. No write-through to dat_out in the same cycle.
- Latency: a word pushed at edge N appears on dat_out with out_valid=1 from just after edge N (first consumable at edge N+1), provided it is the oldest word.
- dat_out: combinational read of entry rd_ptr. Stable while out_valid=1 and no pop occurs.
- count:
  - +1 on push only.
  - -1 on pop only.
  - Otherwise unchanged.
  - Never exceeds DEPTH and never underflows, since rejected requests are ignored.
- available, out_valid and almost_full are combinational decodes of registered count. They carry no combinational path from start_tx or out_ack.

Decomposition:
- Shared package adapter_pkg:
  - function ptr_inc(ptr, depth) implementing the wrap rule.
  - localparam helper for count width, $clog2(DEPTH+1).
- Sub-module adapter_storage: DEPTH x WIDTH register array with a write port (we, waddr, wdata) and an asynchronous read port (raddr, rdata).
- Top module keeps pointers, count and flags.

Test Plan:
- Reset then idle: count=0, available=1, out_valid=0, almost_full=0, tx_complete=0. Drop rst low mid-stream with 3 words stored: count->0 and out_valid->0 immediately, with no clock edge.
- Fill, DEPTH=4: push 0xA1..0xA4 on consecutive cycles, out_ack=0 -> count 1,2,3,4. almost_full asserts at count=3. available=0 after the 4th push. A 5th push of 0xA5 is ignored and count stays 4.
- Drain: out_ack=1 for 4 cycles -> dat_out shows 0xA1,0xA2,0xA3,0xA4 in order. tx_complete pulses once after each pop. out_valid=0 after the last pop. A further out_ack gives no tx_complete.
- Wrap-around, DEPTH=3: run 10 push/pop pairs of 0x00..0x09 with at most 2 words outstanding -> words emerge in order. Pointers cross DEPTH-1->0 at least 3 times.
- Simultaneous push/pop at count=2 -> count stays 2 and ordering is preserved. At count=4 (full) -> pop accepted, push rejected, count=3. At count=0 -> push accepted, no pop, count=1, tx_complete=0.
- Back-pressure: hold out_ack=0 with out_valid=1 for 5 cycles -> dat_out is unchanged across all 5 cycles.
